// File: rtl/dp_local_buffer.sv
//==============================================================================
// Module   : dp_local_buffer
// Purpose  : Dual-port DEPTH x DATA_W local buffer for CNN layer data. Port A
//            has priority. Port B stalls when both ports write the same word.
//            A sweep FSM zero-fills the array after reset or on clr.
// Option   : DP_LB_WR_FWD_EN selects write-first forwarding on a same-address
//            read/write. Without it, such a read returns the old contents.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dp_local_buffer #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 1 << ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              clr,
  output logic              init_done,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,

  output logic [CNT_W-1:0]  coll_cnt
);

  localparam logic [0:0]        c_st_init = 1'b0;
  localparam logic [0:0]        c_st_run  = 1'b1;
  localparam logic [ADDR_W:0]   c_depth   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_last    = ADDR_W'(DEPTH - 1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_a_rvalid, r_b_rvalid;
  logic [DATA_W-1:0] r_a_rdata,  r_b_rdata;
  logic [CNT_W-1:0]  r_coll;

  logic              w_run;
  logic              w_b_stall;
  logic              w_a_acc, w_b_acc;
  logic              w_a_inr, w_b_inr;
  logic              w_a_wr,  w_b_wr;
  logic              w_a_rd,  w_b_rd;
  logic [DATA_W-1:0] w_a_rword, w_b_rword;
  logic [DATA_W-1:0] w_a_rnext, w_b_rnext;

  assign w_run = (r_state == c_st_run);

  // B yields to A only when both ports write the same word in the same cycle.
  assign w_b_stall = w_run & a_req & a_we & b_req & b_we & (a_addr == b_addr);

  assign a_ready = w_run;
  assign b_ready = w_run & ~w_b_stall;

  assign w_a_acc = a_req & a_ready;
  assign w_b_acc = b_req & b_ready;

  assign w_a_inr = ({1'b0, a_addr} < c_depth);
  assign w_b_inr = ({1'b0, b_addr} < c_depth);

  assign w_a_wr = w_a_acc & a_we & w_a_inr;
  assign w_b_wr = w_b_acc & b_we & w_b_inr;
  assign w_a_rd = w_a_acc & ~a_we;
  assign w_b_rd = w_b_acc & ~b_we;

`ifdef DP_LB_WR_FWD_EN
  assign w_a_rword = (w_b_wr && (b_addr == a_addr)) ? b_wdata : r_mem[a_addr];
  assign w_b_rword = (w_a_wr && (a_addr == b_addr)) ? a_wdata : r_mem[b_addr];
`else
  assign w_a_rword = r_mem[a_addr];
  assign w_b_rword = r_mem[b_addr];
`endif

  // Out-of-range reads return zero without touching the array.
  assign w_a_rnext = w_a_inr ? w_a_rword : '0;
  assign w_b_rnext = w_b_inr ? w_b_rword : '0;

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_state <= c_st_init;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_st_init: begin
          if (clr) begin
            r_cnt <= '0;
          end else if (r_cnt == c_last) begin
            r_state <= c_st_run;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        c_st_run: begin
          if (clr) begin
            r_state <= c_st_init;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= c_st_init;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // The array itself is never reset; the sweep writes zeros instead.
  always_ff @(posedge CK) begin
    if (!w_run) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_a_wr) r_mem[a_addr] <= a_wdata;
      if (w_b_wr) r_mem[b_addr] <= b_wdata;
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
      r_coll     <= '0;
    end else begin
      // A clear kills the valid of a read accepted in the same cycle.
      r_a_rvalid <= w_a_rd & ~clr;
      r_b_rvalid <= w_b_rd & ~clr;
      if (w_a_rd) r_a_rdata <= w_a_rnext;
      if (w_b_rd) r_b_rdata <= w_b_rnext;
      if (w_b_stall && !(&r_coll)) r_coll <= r_coll + CNT_W'(1);
    end
  end

  assign init_done = w_run;
  assign a_rvalid  = r_a_rvalid;
  assign b_rvalid  = r_b_rvalid;
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;
  assign coll_cnt  = r_coll;

endmodule

`default_nettype wire

// File: tb/tb_dp_local_buffer.sv
// Self-checking bench for dp_local_buffer: directed vector table, randomized
// traffic against a behavioural model, and clear/reset sequences.
`default_nettype none

module tb_dp_local_buffer;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 48;
  localparam int CNT_W  = 16;
`ifdef DP_LB_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              CK = 1'b0, RST = 1'b0, clr = 1'b0;
  logic              init_done;
  logic              a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic [DATA_W-1:0] a_wdata = '0, b_wdata = '0;
  logic              a_ready, a_rvalid, b_ready, b_rvalid;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic [CNT_W-1:0]  coll_cnt;

  dp_local_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CK(CK), .RST(RST), .clr(clr), .init_done(init_done),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .coll_cnt(coll_cnt)
  );

  always #5 CK = ~CK;

  typedef struct {
    bit                a_req, a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    bit                b_req, b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
  } port_in_t;

  typedef struct {
    port_in_t          in;
    bit                exp_b_ready, exp_a_rvalid, exp_b_rvalid;
    logic [DATA_W-1:0] exp_a_rdata, exp_b_rdata;
    int                exp_coll;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [DATA_W-1:0] m_mem [1 << ADDR_W];
  int                m_coll;
  bit                m_a_rvalid, m_b_rvalid;
  logic [DATA_W-1:0] m_a_rdata, m_b_rdata;

  task automatic chkw(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic bit stalls(input port_in_t p);
    return p.a_req && p.a_we && p.b_req && p.b_we && (p.a_addr == p.b_addr);
  endfunction

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] addr, input bit other_wr,
                                                    input logic [ADDR_W-1:0] oaddr, input logic [DATA_W-1:0] odata);
    if (int'(addr) >= DEPTH) return '0;
    if (FWD && other_wr && (oaddr == addr)) return odata;
    return m_mem[addr];
  endfunction

  task automatic model_zero_mem();
    for (int i = 0; i < (1 << ADDR_W); i++) m_mem[i] = '0;
  endtask

  task automatic model_reset();
    model_zero_mem();
    m_coll = 0;
    m_a_rvalid = 1'b0;
    m_b_rvalid = 1'b0;
    m_a_rdata = '0;
    m_b_rdata = '0;
  endtask

  task automatic model_step(input port_in_t p);
    bit st, b_acc;
    logic [DATA_W-1:0] av, bv;
    st    = stalls(p);
    b_acc = p.b_req && !st;
    av = model_read(p.a_addr, b_acc && p.b_we, p.b_addr, p.b_wdata);
    bv = model_read(p.b_addr, p.a_req && p.a_we, p.a_addr, p.a_wdata);
    m_a_rvalid = p.a_req && !p.a_we;
    m_b_rvalid = b_acc && !p.b_we;
    if (m_a_rvalid) m_a_rdata = av;
    if (m_b_rvalid) m_b_rdata = bv;
    if (p.a_req && p.a_we && int'(p.a_addr) < DEPTH) m_mem[p.a_addr] = p.a_wdata;
    if (b_acc && p.b_we && int'(p.b_addr) < DEPTH) m_mem[p.b_addr] = p.b_wdata;
    if (st && m_coll < (1 << CNT_W) - 1) m_coll++;
  endtask

  function automatic port_in_t idle();
    port_in_t p;
    p.a_req = 0; p.a_we = 0; p.a_addr = '0; p.a_wdata = '0;
    p.b_req = 0; p.b_we = 0; p.b_addr = '0; p.b_wdata = '0;
    return p;
  endfunction

  task automatic drive(input port_in_t p);
    a_req = p.a_req; a_we = p.a_we; a_addr = p.a_addr; a_wdata = p.a_wdata;
    b_req = p.b_req; b_we = p.b_we; b_addr = p.b_addr; b_wdata = p.b_wdata;
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // One bus cycle: starts and ends 1 time unit after a rising edge.
  task automatic run_cycle(input vec_t v, input bit use_tbl);
    drive(v.in);
    #1;
    if (v.in.a_req) chk1("a_ready", a_ready, 1'b1);
    if (v.in.b_req) chk1("b_ready", b_ready, use_tbl ? v.exp_b_ready : !stalls(v.in));
    model_step(v.in);
    tick();
    if (use_tbl) begin
      chk1("a_rvalid", a_rvalid, v.exp_a_rvalid);
      chk1("b_rvalid", b_rvalid, v.exp_b_rvalid);
      chkw("a_rdata", a_rdata, v.exp_a_rdata);
      chkw("b_rdata", b_rdata, v.exp_b_rdata);
      chki("coll_cnt", int'(coll_cnt), v.exp_coll);
    end else begin
      chk1("a_rvalid", a_rvalid, m_a_rvalid);
      chk1("b_rvalid", b_rvalid, m_b_rvalid);
      chkw("a_rdata", a_rdata, m_a_rdata);
      chkw("b_rdata", b_rdata, m_b_rdata);
      chki("coll_cnt", int'(coll_cnt), m_coll);
    end
  endtask

  task automatic count_init(input string name);
    int n = 0;
    while (!init_done && n < 4 * DEPTH) begin
      tick();
      n++;
    end
    chki(name, n, DEPTH);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic read_all(input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.in = idle();
      v.in.a_req = 1; v.in.a_addr = ADDR_W'(i);
      v.in.b_req = 1; v.in.b_addr = ADDR_W'(n - 1 - i);
      run_cycle(v, 1'b0);
    end
  endtask

  function automatic vec_t mk(input bit ar, aw, input int aa, input logic [DATA_W-1:0] ad,
                              input bit br, bw, input int ba, input logic [DATA_W-1:0] bd,
                              input bit ebr, input bit eav, input logic [DATA_W-1:0] ead,
                              input bit ebv, input logic [DATA_W-1:0] ebd, input int ec);
    vec_t v;
    v.in.a_req = ar; v.in.a_we = aw; v.in.a_addr = ADDR_W'(aa); v.in.a_wdata = ad;
    v.in.b_req = br; v.in.b_we = bw; v.in.b_addr = ADDR_W'(ba); v.in.b_wdata = bd;
    v.exp_b_ready = ebr; v.exp_a_rvalid = eav; v.exp_a_rdata = ead;
    v.exp_b_rvalid = ebv; v.exp_b_rdata = ebd; v.exp_coll = ec;
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] raddr();
    if ($urandom_range(0, 9) < 7) return ADDR_W'($urandom_range(0, 5));
    return ADDR_W'($urandom_range(DEPTH - 2, DEPTH + 1));
  endfunction

  function automatic logic [DATA_W-1:0] rword();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    vec_t tbl [15];
    vec_t v;
    port_in_t p, prev;
    bit held;
    logic [DATA_W-1:0] Z, VAA, V11, V22, V01, V33, V44, VFF, V5A;
    Z = '0; VAA = {16{8'hAA}}; V11 = {16{8'h11}}; V22 = {16{8'h22}}; V01 = {16{8'h01}};
    V33 = {16{8'h33}}; V44 = {16{8'h44}}; VFF = {16{8'hFF}}; V5A = {16{8'h5A}};

    //            A: req we addr data      B: req we addr data   b_rdy a_rv a_rdata            b_rv b_rdata            coll
    tbl[0]  = mk(1,1, 5,VAA,  0,0, 0,Z,    1, 0,Z,                0,Z,                  0);
    tbl[1]  = mk(0,0, 0,Z,    1,0, 5,Z,    1, 0,Z,                1,VAA,                0);
    tbl[2]  = mk(1,1, 9,V11,  1,1, 9,V22,  0, 0,Z,                0,VAA,                1);
    tbl[3]  = mk(0,0, 0,Z,    1,1, 9,V22,  1, 0,Z,                0,VAA,                1);
    tbl[4]  = mk(1,0, 9,Z,    0,0, 0,Z,    1, 1,V22,              0,VAA,                1);
    tbl[5]  = mk(1,1, 3,V01,  0,0, 0,Z,    1, 0,V22,              0,VAA,                1);
    tbl[6]  = mk(1,1, 3,V33,  1,0, 3,Z,    1, 0,V22,              1,FWD ? V33 : V01,    1);
    tbl[7]  = mk(1,0, 7,Z,    1,1, 7,V44,  1, 1,FWD ? V44 : Z,    0,FWD ? V33 : V01,    1);
    tbl[8]  = mk(1,0, 5,Z,    1,0, 5,Z,    1, 1,VAA,              1,VAA,                1);
    tbl[9]  = mk(1,1,50,VFF,  1,0,50,Z,    1, 0,VAA,              1,Z,                  1);
    tbl[10] = mk(1,0,50,Z,    0,0, 0,Z,    1, 1,Z,                0,Z,                  1);
    tbl[11] = mk(0,0, 0,Z,    0,0, 0,Z,    1, 0,Z,                0,Z,                  1);
    tbl[12] = mk(1,0, 3,Z,    1,0, 9,Z,    1, 1,V33,              1,V22,                1);
    tbl[13] = mk(1,1,47,V44,  0,0, 0,Z,    1, 0,V33,              0,V22,                1);
    tbl[14] = mk(0,0, 0,Z,    1,0,47,Z,    1, 0,V33,              1,V44,                1);

    // Reset state
    #1 RST = 1'b1;
    #2;
    chk1("rst_init_done", init_done, 1'b0);
    chk1("rst_a_ready", a_ready, 1'b0);
    chk1("rst_b_ready", b_ready, 1'b0);
    chk1("rst_a_rvalid", a_rvalid, 1'b0);
    chk1("rst_b_rvalid", b_rvalid, 1'b0);
    chkw("rst_a_rdata", a_rdata, Z);
    chkw("rst_b_rdata", b_rdata, Z);
    chki("rst_coll_cnt", int'(coll_cnt), 0);
    tick();
    tick();
    RST = 1'b0;
    model_reset();

    // T1: sweep length and zero contents, including out-of-range addresses
    chk1("init_a_ready", a_ready, 1'b0);
    chk1("init_b_ready", b_ready, 1'b0);
    count_init("init_sweep_len");
    read_all(1 << ADDR_W);

    // T2-T4 and boundaries: directed table
    for (int i = 0; i < 15; i++) run_cycle(tbl[i], 1'b1);

    // Randomized traffic; a stalled B request is held unchanged
    held = 0;
    prev = idle();
    for (int n = 0; n < 400; n++) begin
      p.a_req = ($urandom_range(0, 3) != 0); p.a_we = 1'($urandom_range(0, 1));
      p.a_addr = raddr(); p.a_wdata = rword();
      if (held) begin
        p.b_req = prev.b_req; p.b_we = prev.b_we; p.b_addr = prev.b_addr; p.b_wdata = prev.b_wdata;
      end else begin
        p.b_req = ($urandom_range(0, 3) != 0); p.b_we = 1'($urandom_range(0, 1));
        p.b_addr = raddr(); p.b_wdata = rword();
      end
      v.in = p;
      run_cycle(v, 1'b0);
      held = stalls(p);
      prev = p;
    end
    drive(idle());

    // T5: clr while a read is in flight
    p = idle(); p.a_req = 1; p.a_addr = ADDR_W'(2);
    drive(p);
    pulse_clr();
    drive(idle());
    chk1("clr_rvalid_killed", a_rvalid, 1'b0);
    chk1("clr_init_done_low", init_done, 1'b0);
    model_zero_mem();
    m_a_rvalid = 1'b0;
    count_init("clr_sweep_len");
    read_all(DEPTH);

    // clr during the sweep restarts it
    pulse_clr();
    repeat (10) tick();
    pulse_clr();
    chk1("restart_init_done_low", init_done, 1'b0);
    count_init("restart_sweep_len");

    // T6: RST mid-sweep with non-zero outputs beforehand
    v.in = idle(); v.in.a_req = 1; v.in.a_we = 1; v.in.a_addr = ADDR_W'(1); v.in.a_wdata = V5A;
    run_cycle(v, 1'b0);
    v.in = idle(); v.in.a_req = 1; v.in.a_addr = ADDR_W'(1);
    run_cycle(v, 1'b0);
    drive(idle());
    pulse_clr();
    repeat (20) tick();
    chk1("mid_init_done_low", init_done, 1'b0);
    RST = 1'b1;
    #2;
    chk1("rst2_init_done", init_done, 1'b0);
    chk1("rst2_a_ready", a_ready, 1'b0);
    chk1("rst2_b_ready", b_ready, 1'b0);
    chk1("rst2_a_rvalid", a_rvalid, 1'b0);
    chk1("rst2_b_rvalid", b_rvalid, 1'b0);
    chkw("rst2_a_rdata", a_rdata, Z);
    chkw("rst2_b_rdata", b_rdata, Z);
    chki("rst2_coll_cnt", int'(coll_cnt), 0);
    tick();
    RST = 1'b0;
    model_reset();
    count_init("rst2_sweep_len");
    v.in = idle(); v.in.a_req = 1; v.in.a_addr = ADDR_W'(1);
    run_cycle(v, 1'b0);
    drive(idle());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
